// File: rtl/sdp_y_cfg_triosy_pkg.sv
// Shared definitions for the Y-core triosy collector.
// Contents: the collector state enum, the bit positions inside err_status,
//           and the default watchdog limit.
package sdp_y_cfg_triosy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ERR_LZ      = 0;  // strobe nobody was waiting for
  localparam int ERR_START   = 1;  // launch while a layer is in flight
  localparam int ERR_TIMEOUT = 2;  // watchdog expired in WAIT

  localparam int TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/sdp_y_cfg_triosy_collector_if.sv
// Sequencer/core-facing bundle of the triosy collector.
// master: the sequencer/core side (drives op_start, ch_mask, triosy_lz, err_clr)
// slave : the collector (drives op_busy, cfg_lock, op_done, ch_pending,
//         layer_cnt, err_status)
interface sdp_y_cfg_triosy_collector_if #(
  parameter int NUM_CH      = 8,
  parameter int LAYER_CNT_W = 8
);
  logic                   op_start;
  logic [NUM_CH-1:0]      ch_mask;
  logic [NUM_CH-1:0]      triosy_lz;
  logic                   err_clr;
  logic                   op_busy;
  logic                   cfg_lock;
  logic                   op_done;
  logic [NUM_CH-1:0]      ch_pending;
  logic [LAYER_CNT_W-1:0] layer_cnt;
  logic [2:0]             err_status;

  modport master (
    output op_start, ch_mask, triosy_lz, err_clr,
    input  op_busy, cfg_lock, op_done, ch_pending, layer_cnt, err_status
  );

  modport slave (
    input  op_start, ch_mask, triosy_lz, err_clr,
    output op_busy, cfg_lock, op_done, ch_pending, layer_cnt, err_status
  );
endinterface

// File: rtl/sdp_y_cfg_triosy_ch.sv
// One triosy channel: pending flop plus unexpected-strobe detect.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : accepted launch, pending <= ~mask_i
//   mask_i        : channel bypass bit for this launch
//   wait_i        : collector is in WAIT (strobes may retire pending)
//   clr_i         : watchdog abort, drop pending
//   lz_i          : consumption strobe from the core
//   pend_o        : registered pending bit
//   left_o        : pending bit after this cycle's strobe (completion detect)
//   unexp_o       : strobe arrived when this channel was not waiting for one
module sdp_y_cfg_triosy_ch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic mask_i,
  input  logic wait_i,
  input  logic clr_i,
  input  logic lz_i,
  output logic pend_o,
  output logic left_o,
  output logic unexp_o
);
  logic pend_q, pend_d;

  assign left_o  = pend_q & ~(wait_i & lz_i);
  // A strobe only counts while WAITing on a still-pending channel; a strobe
  // landing together with the launch is therefore unexpected as well.
  assign unexp_o = lz_i & ~(wait_i & pend_q);

  always_comb begin
    pend_d = left_o;
    if (clr_i)  pend_d = 1'b0;
    if (load_i) pend_d = ~mask_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= 1'b0;
    else         pend_q <= pend_d;
  end

  assign pend_o = pend_q;
endmodule

// File: rtl/sdp_y_cfg_triosy_collector.sv
// Configuration-side triosy collector: launches a layer, locks the config,
// waits for every enabled channel's lz strobe, then pulses op_done.
// Ports:
//   nvdla_core_clk  : clock
//   nvdla_core_rstn : async active-low reset
//   bus (slave)     : op_start/ch_mask/triosy_lz/err_clr in,
//                     op_busy/cfg_lock/op_done/ch_pending/layer_cnt/err_status out
// Optional feature: SDP_Y_CFG_TRIOSY_TIMEOUT_EN builds a WAIT watchdog of
// TIMEOUT_CYC cycles; without it err_status[2] is tied low.
module sdp_y_cfg_triosy_collector
  import sdp_y_cfg_triosy_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int LAYER_CNT_W = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  sdp_y_cfg_triosy_collector_if.slave bus
);
  state_e                 state_q, state_d;
  logic                   busy_q, done_q;
  logic [LAYER_CNT_W-1:0] cnt_q;
  logic [2:0]             err_q, err_set;
  logic [NUM_CH-1:0]      pend_q, pend_left, unexp;
  logic                   start_acc, in_wait, all_clear, timeout;

  assign in_wait   = (state_q == ST_WAIT);
  assign start_acc = (state_q == ST_IDLE) && bus.op_start;
  assign all_clear = ~|pend_left;

  sdp_y_cfg_triosy_ch u_ch [NUM_CH-1:0] (
    .clk_i  (nvdla_core_clk),
    .rst_ni (nvdla_core_rstn),
    .load_i (start_acc),
    .mask_i (bus.ch_mask),
    .wait_i (in_wait),
    .clr_i  (timeout),
    .lz_i   (bus.triosy_lz),
    .pend_o (pend_q),
    .left_o (pend_left),
    .unexp_o(unexp)
  );

`ifdef SDP_Y_CFG_TRIOSY_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) wd_q <= '0;
    else if (start_acc)   wd_q <= '0;
    else if (in_wait)     wd_q <= wd_q + WD_W'(1);
  end

  // Fires in the TIMEOUT_CYC-th WAIT cycle; a strobe that completes the
  // layer in that same cycle wins.
  assign timeout = in_wait && !all_clear && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.op_start) state_d = (&bus.ch_mask) ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (all_clear)    state_d = ST_DONE;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_set[ERR_LZ]      = |unexp;
  assign err_set[ERR_START]   = bus.op_start && (state_q != ST_IDLE);
  assign err_set[ERR_TIMEOUT] = timeout;

  // Outputs are registered off state_d so they line up with the new state.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      if (state_q == ST_DONE) cnt_q <= cnt_q + LAYER_CNT_W'(1);
      err_q   <= err_set | (err_q & ~{3{bus.err_clr}});
    end
  end

  assign bus.op_busy    = busy_q;
  assign bus.cfg_lock   = busy_q;
  assign bus.op_done    = done_q;
  assign bus.ch_pending = pend_q;
  assign bus.layer_cnt  = cnt_q;
  assign bus.err_status = err_q;
endmodule

// File: doc/sdp_y_cfg_triosy_collector.md
# sdp_y_cfg_triosy_collector

Configuration-side responder for the Y-core triosy handshake. Each Y-core config operand, such as `cfg_mul_op`, reports consumption through a one-cycle triosy `lz` strobe. This block sits in the SDP register/sequencer path. It launches a layer, holds the config registers locked, collects the strobes from all enabled channels, and then signals layer completion back to the sequencer.

## Interface
Parameters:
- `NUM_CH`, 8: number of triosy channels monitored.
- `LAYER_CNT_W`, 8: width of the layer counter.
- `TIMEOUT_CYC`, 4096: watchdog limit in cycles. Used only when the watchdog is compiled in.

Ports:
- `nvdla_core_clk` in 1: the single clock.
- `nvdla_core_rstn` in 1: asynchronous, active-low reset.
- `op_start` in 1: one-cycle layer launch request from the sequencer.
- `ch_mask` in `NUM_CH`: 1 means the channel is bypassed. Sampled only on an accepted `op_start`.
- `triosy_lz` in `NUM_CH`: per-channel one-cycle consumption strobes from the core.
- `err_clr` in 1: clears `err_status`.
- `op_busy` out 1: a layer is in flight.
- `cfg_lock` out 1: the register file must hold the config stable while this is high.
- `op_done` out 1: one-cycle completion pulse.
- `ch_pending` out `NUM_CH`: channels still awaiting their strobe.
- `layer_cnt` out `LAYER_CNT_W`: count of completed layers.
- `err_status` out 3: sticky error bits.
  - [0] unexpected `lz`
  - [1] `op_start` while busy
  - [2] watchdog timeout

## Operation
- Reset value of every output is 0. State resets to IDLE.
- The state machine has three states: IDLE, WAIT, DONE.
- In IDLE, `op_start` is accepted:
  - `ch_pending` <= ~`ch_mask`.
  - `cfg_lock` is set and the state goes to WAIT.
  - If `ch_mask` is all ones, the state goes straight to DONE.
- In WAIT, each cycle: `ch_pending` <= `ch_pending` & ~`triosy_lz`. When the next value is zero, the state goes to DONE.
- In DONE:
  - `op_done` = 1 for exactly one cycle.
  - `layer_cnt` increments modulo 2^`LAYER_CNT_W` (wraps to 0).
  - The state goes to IDLE and `cfg_lock` clears.
- `op_busy` = (state != IDLE).
- Unexpected `lz` sets `err_status[0]`. This covers any `triosy_lz` bit:
  - in IDLE,
  - in DONE, or
  - in WAIT on a channel whose pending bit is already 0.

  The strobe is otherwise ignored.
- `op_start` in WAIT or DONE sets `err_status[1]` and is dropped. It is not queued.
- `op_start` and `triosy_lz` in the same IDLE cycle: the `lz` counts as unexpected and does not clear the newly loaded pending bit.
- Error bits are sticky until `err_clr`. If a set event and `err_clr` occur in the same cycle, the set wins.
- Reset mid-operation: everything returns to reset values immediately. No `op_done` is produced.

## Timing
- `op_start` in cycle t gives `op_busy`/`cfg_lock` = 1 and `ch_pending` loaded in cycle t+1.
- The last pending strobe in cycle t gives:
  - `ch_pending` = 0 and `op_done` = 1 in cycle t+1;
  - `layer_cnt` updated, `op_busy`/`cfg_lock` = 0 in cycle t+2.
- The earliest accepted next `op_start` is in cycle t+2.
- All-masked start in cycle t gives `op_done` in t+1.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- Macro: `SDP_Y_CFG_TRIOSY_TIMEOUT_EN`.
- When defined:
  - A watchdog counter of width clog2(`TIMEOUT_CYC`+1) clears on entry to WAIT and counts each WAIT cycle.
  - On reaching `TIMEOUT_CYC`, it sets `err_status[2]`, clears `ch_pending` and `cfg_lock`, and returns to IDLE.
  - A timeout produces no `op_done` and no `layer_cnt` increment.
  - A completing strobe in the timeout cycle takes priority: the layer completes normally.
- When undefined: no counter is built, `err_status[2]` is tied 0, and WAIT has no exit other than completion.

## Structure
- Shared package `sdp_y_cfg_triosy_pkg`: state enum (IDLE/WAIT/DONE), `err_status` bit-index constants, default `TIMEOUT_CYC`.
- Sub-module `sdp_y_cfg_triosy_ch`, instantiated `NUM_CH` times. It holds the per-channel pending flip-flop (load on start, clear on `lz`) and the unexpected-`lz` detect.
- The top level owns the state machine, OR-reduction of the errors, the layer counter, and the watchdog.

## Test plan
- Basic completion: `NUM_CH`=8, mask 0x00, start at t; strobes on ch0..7 at t+3..t+10. Expect `op_done` only at t+11, `layer_cnt` 0→1 at t+12, `cfg_lock` high t+1..t+11.
- Masked channels: mask 0xF0, strobes on ch0..3 simultaneously at t+5. Expect `op_done` at t+6 with `err_status` = 0. All-ones mask: `op_done` at t+1.
- Errors: repeat `lz` on ch2 in WAIT → `err_status[0]`; `op_start` during WAIT → `err_status[1]`, with no second layer. `err_clr` → 0, and the clear loses to a same-cycle set.
- Wrap: `LAYER_CNT_W`=2, four layers → `layer_cnt` sequence 1, 2, 3, 0.
- Reset mid-WAIT (pending 0x0C): all outputs 0 at once, no `op_done`. Next start behaves normally.
- Watchdog (macro defined, `TIMEOUT_CYC`=16): no strobes → `err_status[2]` after 16 WAIT cycles, IDLE, no `op_done`. Completing strobe at the timeout cycle → `op_done`, no error.
